// File: rtl/cpu_mem_responder.sv
// Memory-side responder for CPU instruction/data ports.
// Arbitrates level-held requests onto a 1-cycle-latency SRAM.
module cpu_mem_responder #(
  parameter int ADR_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_read_req,
  input  logic             i_read_w,
  input  logic             i_read_hw,
  input  logic [31:0]      i_read_adr,
  input  logic             d_read_req,
  input  logic             d_read_w,
  input  logic             d_read_hw,
  input  logic [31:0]      d_read_adr,
  input  logic             d_write_req,
  input  logic             d_write_w,
  input  logic             d_write_hw,
  input  logic [31:0]      d_write_adr,
  input  logic [31:0]      d_write_data,
  output logic             read_valid,
  output logic [31:0]      read_data,
  output logic             write_finish,
  output logic [ADR_W-1:0] mem_adr,
  output logic             mem_ren,
  input  logic [31:0]      mem_rdata,
  output logic             mem_wen,
  output logic [3:0]       mem_wbe,
  output logic [31:0]      mem_wdata,
  output logic             err_oor
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    RD_RESP,
    WR_ISSUE,
    WR_RESP
  } state_t;

  state_t state, state_nx;

  logic [ADR_W-1:0] mem_adr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wbe_q;
  logic [1:0]       lo_q;
  logic             w_q;
  logic             hw_q;
  logic             oor_q;

  logic             req_any;
  logic [31:0]      req_adr;
  logic             req_w;
  logic             req_hw;
  logic             req_oor;

  function automatic logic [31:0] rd_fmt(
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic        w,
    input logic        hw
  );
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    if (w)
      return d;
    else if (hw)
      return a[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
    else
      return {24'h0, sh[7:0]};
  endfunction

  function automatic logic [3:0] wr_be(
    input logic [1:0] a,
    input logic       w,
    input logic       hw
  );
    if (w)
      return 4'b1111;
    else if (hw)
      return a[1] ? 4'b1100 : 4'b0011;
    else
      return 4'b0001 << a;
  endfunction

  function automatic logic [31:0] wr_data(
    input logic [31:0] d,
    input logic        w,
    input logic        hw
  );
    if (w)
      return d;
    else if (hw)
      return {2{d[15:0]}};
    else
      return {4{d[7:0]}};
  endfunction

  // Fixed priority: data write, then data read, then fetch.
  always_comb begin
    req_any = 1'b1;
    req_adr = i_read_adr;
    req_w   = i_read_w;
    req_hw  = i_read_hw;
    priority case (1'b1)
      d_write_req: begin
        req_adr = d_write_adr;
        req_w   = d_write_w;
        req_hw  = d_write_hw;
      end
      d_read_req: begin
        req_adr = d_read_adr;
        req_w   = d_read_w;
        req_hw  = d_read_hw;
      end
      i_read_req: begin
      end
      default: req_any = 1'b0;
    endcase
  end

  assign req_oor = |req_adr[31:ADR_W+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    mem_wbe      = 4'b0000;
    read_valid   = 1'b0;
    write_finish = 1'b0;
    err_oor      = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_write_req)
          state_nx = WR_ISSUE;
        else if (d_read_req || i_read_req)
          state_nx = RD_ISSUE;
      end
      RD_ISSUE: begin
        mem_ren  = !oor_q;
        state_nx = RD_CAPT;
      end
      RD_CAPT: state_nx = RD_RESP;
      RD_RESP: begin
        read_valid = 1'b1;
        err_oor    = oor_q;
        state_nx   = IDLE;
      end
      WR_ISSUE: begin
        mem_wen  = !oor_q;
        mem_wbe  = oor_q ? 4'b0000 : wbe_q;
        state_nx = WR_RESP;
      end
      WR_RESP: begin
        write_finish = 1'b1;
        err_oor      = oor_q;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lane formatting is done at latch time so SRAM outputs hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_adr_q <= '0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      lo_q      <= '0;
      w_q       <= 1'b0;
      hw_q      <= 1'b0;
      oor_q     <= 1'b0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req_any) begin
        mem_adr_q <= req_adr[ADR_W+1:2];
        lo_q      <= req_adr[1:0];
        w_q       <= req_w;
        hw_q      <= req_hw;
        oor_q     <= req_oor;
        if (d_write_req) begin
          wdata_q <= wr_data(d_write_data, req_w, req_hw);
          wbe_q   <= wr_be(req_adr[1:0], req_w, req_hw);
        end
      end
      if (state == RD_CAPT)
        read_data <= oor_q ? 32'h0 : rd_fmt(mem_rdata, lo_q, w_q, hw_q);
    end
  end

  assign mem_adr   = mem_adr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU core's instruction-read, data-read and data-write request ports.
- Accepts level-held requests, arbitrates them onto a single-port synchronous SRAM with 1-cycle read latency, and returns the shared read_valid/read_data or write_finish handshake.
- Sits between the CPU top and the on-chip RAM. Handles byte/halfword/word lane extraction and byte-enable generation.

Parameters:
- ADR_W, 12, SRAM word-address width (SRAM depth is 2^ADR_W 32-bit words).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_read_req  in  1  instruction read request, level, held until read_valid
- i_read_w  in  1  instruction read size word
- i_read_hw  in  1  instruction read size halfword (w=0,hw=0 means byte)
- i_read_adr  in  32  instruction byte address
- d_read_req  in  1  data read request, level, held until read_valid
- d_read_w  in  1  data read size word
- d_read_hw  in  1  data read size halfword
- d_read_adr  in  32  data read byte address
- d_write_req  in  1  data write request, level, held until write_finish
- d_write_w  in  1  data write size word
- d_write_hw  in  1  data write size halfword
- d_write_adr  in  32  data write byte address
- d_write_data  in  32  write value, right-justified
- read_valid  out  1  one-cycle pulse, read_data valid
- read_data  out  32  read result, right-justified, zero-extended
- write_finish  out  1  one-cycle pulse, write done
- mem_adr  out  ADR_W  SRAM word address
- mem_ren  out  1  SRAM read enable
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_ren
- mem_wen  out  1  SRAM write enable
- mem_wbe  out  4  SRAM byte enables (bit n = byte lane n, little endian)
- mem_wdata  out  32  SRAM write data
- err_oor  out  1  one-cycle pulse, access out of range

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, read_data 32'h0, FSM in IDLE. Assertion mid-transaction aborts it: no response is given and no pending SRAM write occurs.
- FSM states: IDLE, RD_ISSUE, RD_CAPT, RD_RESP, WR_ISSUE, WR_RESP.
- IDLE arbitration: fixed priority d_write_req > d_read_req > i_read_req.
  - The winner's adr, size and data are latched. Losers stay pending, untouched.
  - A read goes to RD_ISSUE; a write goes to WR_ISSUE.
- RD_ISSUE: mem_ren=1, mem_adr=adr[ADR_W+1:2]. Next state RD_CAPT.
- RD_CAPT: mem_rdata is formatted and registered into read_data. Next state RD_RESP.
  - word: full word; adr[1:0] ignored.
  - halfword: lane selected by adr[1] (0 gives bits 15:0, 1 gives bits 31:16), zero-extended; adr[0] ignored.
  - byte: lane adr[1:0], zero-extended.
- RD_RESP: read_valid=1 for exactly 1 cycle. Next state IDLE.
  - Read latency: req sampled in IDLE at cycle 0, read_valid high in cycle 3.
  - read_data holds its value until the next RD_CAPT.
- WR_ISSUE: mem_wen=1, mem_adr as for reads.
  - word: mem_wbe=4'b1111, mem_wdata=data.
  - halfword: mem_wdata={2{data[15:0]}}, mem_wbe=adr[1]?4'b1100:4'b0011.
  - byte: mem_wdata={4{data[7:0]}}, mem_wbe=4'b0001<<adr[1:0].
  - Next state WR_RESP.
- WR_RESP: write_finish=1 for 1 cycle. Next state IDLE. Write latency: finish in cycle 2.
- Request/response handshake:
  - The requester must drop req in the cycle after the response.
  - The responder re-samples only in IDLE, which is always at least 1 cycle after the response, so a held req is never served twice.
- Size: if w and hw are both 1, w wins.
- Out of range (adr[31:ADR_W+2] != 0):
  - No mem_ren/mem_wen is issued.
  - A read returns 32'h0; a write is dropped.
  - The normal handshake still completes with the same latency.
  - err_oor pulses in the same cycle as read_valid/write_finish.
- Outputs mem_ren, mem_wen and mem_wbe are 0 in every state other than the ones listed above. mem_adr and mem_wdata hold their last value.

Test Plan:
- Preload word 0x10=0xA1B2C3D4. Word i_read at 0x10 -> read_valid in cycle 3 with read_data=0xA1B2C3D4; mem_ren high in cycle 1 only.
- Byte d_read at 0x13 -> 0x000000A1. Halfword d_read at 0x12 -> 0x0000A1B2. Halfword d_read at 0x11 -> 0x0000C3D4 (adr[0] ignored).
- Byte d_write 0x55 at 0x11 -> mem_wbe=4'b0010, mem_wdata=0x55555555, write_finish in cycle 2. A word read of 0x10 afterwards -> 0xA1B255D4.
- d_write_req, d_read_req and i_read_req asserted together -> served in order write, data read, instruction read. Exactly one write_finish and two read_valid pulses; no double service while reqs are held one cycle past the response.
- d_read at 0x0004_0000 with ADR_W=12 -> mem_ren stays 0, read_data=0, read_valid and err_oor pulse together in cycle 3.
- Assert rst_n low during RD_CAPT -> all outputs 0 immediately. After release with the request still held -> a fresh read completes normally with 3-cycle latency.
